framebuffer_scanner: RTL



---
 rtl/lamp_pkg.sv | 29 ++
 rtl/sclk_divider.sv | 51 +++++
 rtl/framebuffer_scanner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lamp_pkg.sv
// ---------------------------------------------------------------------------
// lamp_pkg
// Definitions shared by the framebuffer and its read-side scanner: the
// scanner state enumeration, the board geometry, the default channel word
// width, and a counter-width helper.
// ---------------------------------------------------------------------------
package lamp_pkg;

    // Channels driven by one LED driver board.
    localparam int c_chan_per_board = 32;

    // Default bits per channel word.
    localparam int c_bpc_default = 12;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        LATCH,
        DONE
    } scan_state_t;

    // $clog2(n), but never narrower than one bit, so that a counter which
    // only ever holds 0 still has a legal declaration.
    function automatic int min_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sclk_divider.sv
// ---------------------------------------------------------------------------
// sclk_divider
// Times one serial bit as two phases of c_clkdiv system clocks each.
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous, active-high reset
//   i_en         count while high; held cleared while low
//   o_phase_stb  high in the last cycle of the low phase (SCLK rises next)
//   o_bit_end    high in the last cycle of the high phase (bit complete)
// ---------------------------------------------------------------------------
module sclk_divider
    import lamp_pkg::*;
#(
    parameter int c_clkdiv = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_phase_stb,
    output logic o_bit_end
);

    localparam int                 c_cnt_w    = min_width(c_clkdiv);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_clkdiv - 1);

    logic [c_cnt_w-1:0] cnt;
    logic               phase_hi;

    // NOTE: clocked state is always written with non-blocking assignments so
    // every register samples the values from before the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt      <= '0;
            phase_hi <= 1'b0;
        end else if (!i_en) begin
            // Each enable window starts at the beginning of a low phase.
            cnt      <= '0;
            phase_hi <= 1'b0;
        end else if (cnt == c_cnt_last) begin
            cnt      <= '0;
            phase_hi <= ~phase_hi;
        end else begin
            cnt      <= cnt + c_cnt_w'(1);
        end
    end

    assign o_phase_stb = i_en && (cnt == c_cnt_last) && !phase_hi;
    assign o_bit_end   = i_en && (cnt == c_cnt_last) &&  phase_hi;

endmodule

// File: rtl/framebuffer_scanner.sv
// ---------------------------------------------------------------------------
// framebuffer_scanner
// On each frame request, reads every channel word from the framebuffer
// (highest address first), shifts each word MSB first into the LED driver
// daisy chain, then issues a latch pulse and a one-cycle done strobe.
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous, active-high reset
//   i_start  one-cycle frame request, accepted only in IDLE
//   o_raddr  framebuffer read address
//   i_rdata  framebuffer read data, captured at the end of the 2nd FETCH cycle
//   o_sclk   serial clock; drivers sample on the rising edge
//   o_sdata  serial data, MSB first
//   o_latch  latch pulse, c_latch_cycles long
//   o_busy   frame in progress
//   o_done   one-cycle strobe when the frame is complete
// ---------------------------------------------------------------------------
module framebuffer_scanner
    import lamp_pkg::*;
#(
    parameter  int c_ledboards    = 30,
    parameter  int c_bpc          = c_bpc_default,
    parameter  int c_clkdiv       = 2,
    parameter  int c_latch_cycles = 4,
    localparam int c_channels     = c_ledboards * c_chan_per_board,
    localparam int c_addr_w       = $clog2(c_channels)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic [c_addr_w-1:0] o_raddr,
    input  logic [c_bpc-1:0]    i_rdata,
    output logic                o_sclk,
    output logic                o_sdata,
    output logic                o_latch,
    output logic                o_busy,
    output logic                o_done
);

    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_channels - 1);
    localparam int                  c_bit_w     = min_width(c_bpc);
    localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(c_bpc - 1);
    localparam int                  c_lat_w     = min_width(c_latch_cycles + 1);
    localparam logic [c_lat_w-1:0]  c_last_lat  = c_lat_w'(c_latch_cycles - 1);

    scan_state_t        state_q, state_d;
    logic [c_bpc-1:0]   shreg;
    logic [c_bit_w-1:0] bit_cnt;
    logic [c_lat_w-1:0] lat_cnt;
    logic               fetch_second;
    logic               sclk_q;
    logic               phase_stb;
    logic               bit_end;

    sclk_divider #(
        .c_clkdiv (c_clkdiv)
    ) u_sclk_divider (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (state_q == SHIFT),
        .o_phase_stb (phase_stb),
        .o_bit_end   (bit_end)
    );

    // ---- state register ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    // NOTE: the default assignment at the top of every combinational block
    // keeps each path fully specified, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = FETCH;
            FETCH:   if (fetch_second) state_d = SHIFT;
            SHIFT:   if (bit_end && (bit_cnt == '0))
                         state_d = (o_raddr == '0) ? LATCH : FETCH;
            LATCH:   if (lat_cnt == c_last_lat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- outputs ----
    always_comb begin
        o_busy  = 1'b0;
        o_latch = 1'b0;
        o_done  = 1'b0;
        o_sdata = 1'b0;
        case (state_q)
            FETCH:   o_busy = 1'b1;
            SHIFT: begin
                o_busy  = 1'b1;
                o_sdata = shreg[c_bpc-1];
            end
            LATCH: begin
                o_busy  = 1'b1;
                o_latch = 1'b1;
            end
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    // SCLK is registered from the divider strobes. bit_end always precedes
    // leaving SHIFT, so it is guaranteed low in every other state.
    assign o_sclk = sclk_q;

    // ---- datapath ----
    // NOTE: the shift register is an ordinary register, not a memory, so it
    // is cleared on reset along with the counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_raddr      <= c_last_addr;
            shreg        <= '0;
            bit_cnt      <= '0;
            lat_cnt      <= '0;
            fetch_second <= 1'b0;
            sclk_q       <= 1'b0;
        end else begin
            // Marks the second of the two FETCH cycles.
            fetch_second <= (state_q == FETCH) && !fetch_second;

            // Tops out at c_latch_cycles, which fits the counter width.
            lat_cnt <= (state_q == LATCH) ? lat_cnt + c_lat_w'(1) : '0;

            if (bit_end) begin
                sclk_q <= 1'b0;
            end else if (phase_stb) begin
                sclk_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (i_start) o_raddr <= c_last_addr;
                end
                FETCH: begin
                    // o_raddr has been stable since entering FETCH, so the
                    // framebuffer's output register holds this word now.
                    if (fetch_second) begin
                        shreg   <= i_rdata;
                        bit_cnt <= c_last_bit;
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        if (bit_cnt == '0) begin
                            // Address stops at 0; reloaded on the next start.
                            if (o_raddr != '0) o_raddr <= o_raddr - c_addr_w'(1);
                        end else begin
                            shreg   <= {shreg[c_bpc-2:0], 1'b0};
                            bit_cnt <= bit_cnt - c_bit_w'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
